// File: rtl/dmd_pkg.sv
// Shared definitions for the double multiplier driver.
//   dmd_state_e   : driver FSM state encoding
//   QNAN_D        : quiet NaN placed in res_z when a transaction is aborted
//   is_wait_state : true for states guarded by the handshake timeout
package dmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSendA,
        StSendB,
        StWaitZ,
        StResult
    } dmd_state_e;

    localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;

    function automatic logic is_wait_state(input dmd_state_e s);
        return (s == StSendA) || (s == StSendB) || (s == StWaitZ);
    endfunction

endpackage

// File: rtl/hs_timeout_counter.sv
// Handshake wait counter.
// Counts cycles spent waiting for a handshake partner and flags when the
// budget of TIMEOUT cycles is used up.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears the count
//   clear   : restart the count from zero (wins over enable)
//   enable  : count one more waiting cycle
//   expired : count has reached TIMEOUT-1
module hs_timeout_counter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // Saturates at LAST so a caller that lingers cannot wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/double_mult_driver.sv
// Double-precision multiplier driver.
// Accepts an operand pair, feeds A then B to a strobe/ack multiplier, waits
// for the product and presents it as a result with valid/ready. Each wait
// state is bounded by TIMEOUT cycles; on expiry the transaction is aborted
// with res_err set and a quiet NaN as the result.
//   clk, rst                          : clock, async active-high reset
//   op_a, op_b, op_valid, op_ready    : operand pair in
//   input_a, input_a_stb, input_a_ack : operand A to multiplier
//   input_b, input_b_stb, input_b_ack : operand B to multiplier
//   output_z, output_z_stb, output_z_ack : product from multiplier
//   res_z, res_err, res_valid, res_ready : result out
//   txn_count                          : completed transactions (wraps)
module double_mult_driver
    import dmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      op_a,
    input  logic [63:0]      op_b,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [63:0]      input_a,
    output logic             input_a_stb,
    input  logic             input_a_ack,
    output logic [63:0]      input_b,
    output logic             input_b_stb,
    input  logic             input_b_ack,
    input  logic [63:0]      output_z,
    input  logic             output_z_stb,
    output logic             output_z_ack,
    output logic [63:0]      res_z,
    output logic             res_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] txn_count
);

    dmd_state_e  state_q;
    logic [63:0] b_lat_q;

    logic accept;
    logic a_xfer;
    logic b_xfer;
    logic z_xfer;
    logic in_wait;
    logic wait_clear;
    logic expired;
    logic timed_out;

    // Each stb/ack output is only ever high in its own state, so a transfer
    // flag implies the matching state.
    always_comb begin
        accept     = op_valid && op_ready;
        a_xfer     = input_a_stb && input_a_ack;
        b_xfer     = input_b_stb && input_b_ack;
        z_xfer     = output_z_stb && output_z_ack;
        in_wait    = is_wait_state(state_q);
        wait_clear = accept || a_xfer || b_xfer;
        // A transfer on the expiry edge still completes normally.
        timed_out  = in_wait && expired && !(a_xfer || b_xfer || z_xfer);
    end

    hs_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clear   (wait_clear),
        .enable  (in_wait),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            b_lat_q      <= '0;
            op_ready     <= 1'b1;
            input_a      <= '0;
            input_a_stb  <= 1'b0;
            input_b      <= '0;
            input_b_stb  <= 1'b0;
            output_z_ack <= 1'b0;
            res_z        <= '0;
            res_err      <= 1'b0;
            res_valid    <= 1'b0;
            txn_count    <= '0;
        end else if (timed_out) begin
            input_a_stb  <= 1'b0;
            input_b_stb  <= 1'b0;
            output_z_ack <= 1'b0;
            res_z        <= QNAN_D;
            res_err      <= 1'b1;
            res_valid    <= 1'b1;
            state_q      <= StResult;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        input_a     <= op_a;
                        b_lat_q     <= op_b;
                        input_a_stb <= 1'b1;
                        op_ready    <= 1'b0;
                        state_q     <= StSendA;
                    end
                end
                StSendA: begin
                    if (a_xfer) begin
                        input_a_stb <= 1'b0;
                        input_b     <= b_lat_q;
                        input_b_stb <= 1'b1;
                        state_q     <= StSendB;
                    end
                end
                StSendB: begin
                    if (b_xfer) begin
                        input_b_stb  <= 1'b0;
                        output_z_ack <= 1'b1;
                        state_q      <= StWaitZ;
                    end
                end
                StWaitZ: begin
                    if (z_xfer) begin
                        res_z        <= output_z;
                        output_z_ack <= 1'b0;
                        res_err      <= 1'b0;
                        res_valid    <= 1'b1;
                        state_q      <= StResult;
                    end
                end
                StResult: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        txn_count <= txn_count + CNT_W'(1);
                        op_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    op_ready <= 1'b1;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_double_mult_driver.sv
// Self-checking bench for double_mult_driver: directed scenarios followed by
// randomized transactions against a behavioural multiplier responder.
module tb_double_mult_driver;
    import dmd_pkg::*;

    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned CNT_W   = 2;
    localparam int          BOUND   = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic [63:0]      op_a, op_b;
    logic             op_valid, op_ready;
    logic [63:0]      input_a, input_b, output_z, res_z;
    logic             input_a_stb, input_a_ack, input_b_stb, input_b_ack;
    logic             output_z_stb, output_z_ack;
    logic             res_err, res_valid, res_ready;
    logic [CNT_W-1:0] txn_count;

    always #5 clk = ~clk;

    double_mult_driver #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack),
        .res_z        (res_z),
        .res_err      (res_err),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .txn_count    (txn_count)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    function automatic logic [63:0] rand_double();
        logic [63:0] r;
        r[63]    = 1'($urandom_range(0, 1));
        r[62:52] = 11'(960 + $urandom_range(0, 63));
        r[51:32] = 20'($urandom);
        r[31:0]  = $urandom;
        return r;
    endfunction

    // ---------------- multiplier responder model ----------------
    int          a_dly = 0, b_dly = 0, z_dly = 0;
    bit          hold_a = 0, hold_b = 0, hold_z = 0, junk_en = 0;
    int          a_cnt = 0, b_cnt = 0, z_cnt = 0;
    bit          z_pend = 0, z_armed = 0;
    logic [63:0] cap_a = '0, z_val = '0;

    always @(negedge clk) begin
        if (rst) begin
            input_a_ack  = 1'b0;
            input_b_ack  = 1'b0;
            output_z_stb = 1'b0;
            output_z     = '0;
            z_pend       = 0;
            z_armed      = 0;
            a_cnt        = 0;
            b_cnt        = 0;
        end else begin
            if (!input_a_stb) begin
                input_a_ack = 1'b0;
                a_cnt       = 0;
            end else begin
                if (!hold_a && a_cnt >= a_dly && !input_a_ack) begin
                    input_a_ack = 1'b1;
                    cap_a       = input_a;
                end
                a_cnt++;
            end
            if (!input_b_stb) begin
                input_b_ack = 1'b0;
                b_cnt       = 0;
            end else begin
                if (!hold_b && b_cnt >= b_dly && !input_b_ack) begin
                    input_b_ack = 1'b1;
                    z_val       = ref_mul(cap_a, input_b);
                    z_pend      = 1;
                    z_cnt       = 0;
                end
                b_cnt++;
            end
            if (z_armed) begin
                output_z_stb = 1'b0;
                z_armed      = 0;
                z_pend       = 0;
            end else if (z_pend) begin
                if (res_valid) begin
                    z_pend       = 0;
                    output_z_stb = 1'b0;
                end else if (!hold_z && z_cnt >= z_dly) begin
                    output_z_stb = 1'b1;
                    output_z     = z_val;
                end else begin
                    output_z_stb = 1'b0;
                end
                z_cnt++;
                if (output_z_stb && output_z_ack) z_armed = 1;
            end else begin
                // Spurious product strobes while no product is due.
                output_z_stb = junk_en && ($urandom_range(0, 3) == 0);
                output_z     = {$urandom, $urandom};
            end
        end
    end

    // ---------------- protocol monitors ----------------
    int overlap_cnt = 0;
    int ready_viol  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(input_a_stb && input_b_stb)) else overlap_cnt++;
            // op_ready must be high exactly when nothing else is in flight.
            if (op_ready == (input_a_stb || input_b_stb || output_z_ack || res_valid))
                ready_viol++;
        end
    end

    // ---------------- transaction driver ----------------
    task automatic do_txn(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_z,
                          input bit exp_err, input int rdy_dly, output int lat, output int b_first);
        int n;
        bit stable;
        n       = 0;
        lat     = 0;
        b_first = -1;
        while (!op_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check_eq("op_ready_wait", 64'(op_ready), 64'(1));
        if (!op_ready) return;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        lat      = 1;
        while (!res_valid && lat < BOUND) begin
            if (input_b_stb && b_first < 0) b_first = lat;
            @(negedge clk);
            lat++;
        end
        check_eq("res_valid_wait", 64'(res_valid), 64'(1));
        if (!res_valid) return;
        check_eq("res_z", res_z, exp_z);
        check_eq("res_err", 64'(res_err), 64'(exp_err));
        check_eq("stb_ack_clear", 64'({input_a_stb, input_b_stb, output_z_ack}), 64'(0));
        stable = 1;
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            if (res_z !== exp_z || !res_valid || op_ready) stable = 0;
        end
        if (rdy_dly > 0) check_eq("result_hold", 64'(stable), 64'(1));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_done++;
        check_eq("res_valid_clear", 64'(res_valid), 64'(0));
        check_eq("op_ready_idle", 64'(op_ready), 64'(1));
        check_eq("txn_count", 64'(txn_count), 64'(n_done % (1 << CNT_W)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] a, b;
        int          lat, bf, n, k;
        bit          err;

        rst       = 1'b1;
        op_a      = '0;
        op_b      = '0;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Values held while reset is asserted.
        check_eq("rst_op_ready", 64'(op_ready), 64'(1));
        check_eq("rst_stb_ack", 64'({input_a_stb, input_b_stb, output_z_ack}), 64'(0));
        check_eq("rst_res_flags", 64'({res_valid, res_err}), 64'(0));
        check_eq("rst_res_z", res_z, 64'(0));
        check_eq("rst_input_a", input_a, 64'(0));
        check_eq("rst_input_b", input_b, 64'(0));
        check_eq("rst_txn_count", 64'(txn_count), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // 2.0 x 3.0 with immediate acks: minimum latency path.
        do_txn(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h4018_0000_0000_0000,
               0, 0, lat, bf);
        check_eq("min_latency", 64'(lat), 64'(4));
        check_eq("txn_count_first", 64'(txn_count), 64'(1));

        // Reset while waiting for the product.
        hold_z   = 1;
        op_a     = 64'h4000_0000_0000_0000;
        op_b     = 64'h4008_0000_0000_0000;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (!output_z_ack && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_wait_z", 64'(output_z_ack), 64'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_op_ready", 64'(op_ready), 64'(1));
        check_eq("arst_stb_ack", 64'({input_a_stb, input_b_stb, output_z_ack}), 64'(0));
        check_eq("arst_res_flags", 64'({res_valid, res_err}), 64'(0));
        check_eq("arst_res_z", res_z, 64'(0));
        check_eq("arst_input_a", input_a, 64'(0));
        check_eq("arst_input_b", input_b, 64'(0));
        check_eq("arst_txn_count", 64'(txn_count), 64'(0));
        n_done = 0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        hold_z = 0;
        do_txn(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000,
               0, 0, lat, bf);

        // B never acknowledged: abort exactly TIMEOUT cycles after SEND_B entry.
        hold_b = 1;
        do_txn(64'h4000_0000_0000_0000, 64'h4010_0000_0000_0000, QNAN_D, 1, 0, lat, bf);
        check_eq("b_timeout_cycles", 64'(lat - bf), 64'(TIMEOUT));
        hold_b = 0;

        // Consumer stalls for 10 cycles.
        do_txn(64'h4014_0000_0000_0000, 64'hC000_0000_0000_0000, 64'hC024_0000_0000_0000,
               0, 10, lat, bf);

        // Counter wrap over five back-to-back transactions after reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int t = 0; t < 5; t++) begin
            a = rand_double();
            b = rand_double();
            do_txn(a, b, ref_mul(a, b), 0, 0, lat, bf);
        end

        // Randomized delays, timeouts and spurious product strobes.
        junk_en = 1;
        for (int t = 0; t < 40; t++) begin
            a      = rand_double();
            b      = rand_double();
            a_dly  = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3);
            z_dly  = $urandom_range(0, 3);
            k      = $urandom_range(0, 9);
            hold_a = (k == 0);
            hold_b = (k == 1);
            hold_z = (k == 2);
            err    = hold_a || hold_b || hold_z;
            do_txn(a, b, err ? QNAN_D : ref_mul(a, b), err, $urandom_range(0, 3), lat, bf);
        end
        hold_a  = 0;
        hold_b  = 0;
        hold_z  = 0;
        junk_en = 0;

        check_eq("stb_overlap", 64'(overlap_cnt), 64'(0));
        check_eq("op_ready_only_idle", 64'(ready_viol), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/double_mult_driver.md
DOUBLE_MULT_DRIVER -- requirements
Module: double_mult_driver

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- TIMEOUT  1024  max cycles spent in any wait state before abort
- CNT_W  16  width of the completed-transaction counter
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- op_a  in  64  IEEE-754 double operand A
- op_b  in  64  IEEE-754 double operand B
- op_valid  in  1  operand pair offered
- op_ready  out  1  driver accepts operand pair
- input_a  out  64  operand A to multiplier
- input_a_stb  out  1  A strobe
- input_a_ack  in  1  multiplier ready for A
- input_b  out  64  operand B to multiplier
- input_b_stb  out  1  B strobe
- input_b_ack  in  1  multiplier ready for B
- output_z  in  64  product from multiplier
- output_z_stb  in  1  product valid
- output_z_ack  out  1  product taken
- res_z  out  64  captured product
- res_err  out  1  transaction aborted by timeout
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- txn_count  out  CNT_W  completed transactions, error or not

Function
REQ-003 The driver SHALL be a single FSM with states IDLE, SEND_A, SEND_B, WAIT_Z, RESULT; all outputs registered.
REQ-004 op_ready SHALL be 1 only in IDLE.
REQ-005 On op_valid && op_ready: latch op_a and op_b; next cycle input_a = latched A, input_a_stb = 1, state SEND_A.
REQ-006 Handshake rule: a transfer occurs on a rising edge where stb (or ack, for output side) and the partner signal are both 1; a strobe SHALL remain high until its transfer completes.
REQ-007 SEND_A: on input_a_stb && input_a_ack, set input_a_stb to 0, input_b = latched B, input_b_stb to 1, and go to SEND_B.
REQ-008 SEND_B: on input_b_stb && input_b_ack, set input_b_stb to 0, output_z_ack to 1, and go to WAIT_Z.
REQ-009 WAIT_Z: on output_z_stb && output_z_ack, capture output_z into res_z, set output_z_ack to 0, res_err to 0, res_valid to 1, and go to RESULT.
REQ-010 RESULT: hold res_z, res_err and res_valid until res_valid && res_ready; then clear res_valid, increment txn_count (wraps modulo 2^CNT_W), and go to IDLE.
REQ-011 Minimum latency, with immediate acks: operand accept to res_valid = 4 cycles; input_a_stb and input_b_stb SHALL never both be 1.
REQ-012 A wait counter SHALL clear on entry to SEND_A, SEND_B and WAIT_Z, and otherwise increment each cycle in those states.
REQ-013 When the wait counter reaches TIMEOUT-1 without a transfer, the FSM SHALL clear all stb/ack outputs, set res_z = 64'h7FF8_0000_0000_0000, res_err = 1 and res_valid = 1, and go to RESULT.
REQ-014 If a transfer and the timeout coincide, the transfer SHALL win.
REQ-015 The driver SHALL ignore output_z_stb outside WAIT_Z.

Reset
REQ-016 While rst = 1, the FSM SHALL be in IDLE with these output values:
- op_ready 1
- all stb/ack outputs 0
- res_valid 0, res_err 0
- res_z, input_a, input_b 0
- txn_count 0
- wait counter 0
REQ-017 A reset asserted mid-transaction SHALL abandon it without incrementing txn_count.

Structure
REQ-018 A shared package dmd_pkg SHALL hold the state enum typedef and the QNAN_D constant 64'h7FF8_0000_0000_0000.
REQ-019 The wait counter SHALL be a separate sub-module, hs_timeout_counter, with inputs clear and enable and output expired.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- 4000000000000000 x 4008000000000000 against the real multiplier -> res_z = 4018000000000000, res_err = 0, txn_count = 1.
- Responder holds input_b_ack at 0 -> exactly TIMEOUT cycles after SEND_B entry, res_valid = 1, res_err = 1, res_z = 7FF8000000000000, input_b_stb = 0.
- res_ready held at 0 for 10 cycles after res_valid -> res_z stable, op_ready = 0 throughout; on release, IDLE next cycle.
- rst pulsed in WAIT_Z -> outputs take reset values immediately, txn_count unchanged at 0; a following 3FF0000000000000 x 3FF0000000000000 completes with 3FF0000000000000.
- CNT_W = 2, five back-to-back transactions -> txn_count sequence 1, 2, 3, 0, 1.
- Model responder with immediate acks -> res_valid 4 cycles after accept; input_a_stb and input_b_stb never overlap (assertion).
